// File: rtl/pll_lock_ctrl.sv
// Bang-bang PLL loop controller: walks the DCO code from PFD up/dn samples
// through coarse acquisition and fine tracking, then declares lock.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | code parked at CODE_INIT, all counters cleared
// ACQUIRE  | coarse steps until FLIP_CNT direction reversals are seen
// TRACK    | fine steps, windowed balance evaluation, counting good windows
// LOCKED   | fine steps, lock flag high until a window comes out unbalanced
`timescale 1ns/1ps
module pll_lock_ctrl #(
    parameter int CODE_W      = 8,
    parameter int CODE_INIT   = 128,
    parameter int STEP_COARSE = 8,
    parameter int STEP_FINE   = 1,
    parameter int FLIP_CNT    = 4,
    parameter int WIN_LEN     = 32,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_WINS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [CODE_W-1:0] dco_code,
    output logic              locked,
    output logic [1:0]        state
);

    localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int BAL_W  = WIN_W + 2;
    localparam int FLIP_W = $clog2(FLIP_CNT + 1);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CODE_W-1:0]         code_q, code_d;
    logic                      locked_q, locked_d;
    logic [FLIP_W-1:0]         flip_q, flip_d;
    logic [WIN_W-1:0]          win_q, win_d;
    logic signed [BAL_W-1:0]   bal_q, bal_d;
    logic [GOOD_W-1:0]         good_q, good_d;
    logic                      last_up_q, last_up_d;
    logic                      last_dn_q, last_dn_d;
    logic                      dir_up_q, dir_dn_q;

    logic [CODE_W-1:0]         step;
    logic [CODE_W-1:0]         code_step;
    logic signed [BAL_W-1:0]   dir_val;
    logic signed [BAL_W-1:0]   bal_sum;
    logic [BAL_W-1:0]          bal_mag;
    logic                      balanced;
    logic                      win_last;
    logic                      reversal;

    // One-cycle sample stage: the code reacts to the direction seen on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_up_q <= 1'b0;
            dir_dn_q <= 1'b0;
        end else begin
            dir_up_q <= up & ~dn;
            dir_dn_q <= dn & ~up;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            code_q    <= CODE_RST;
            locked_q  <= 1'b0;
            flip_q    <= '0;
            win_q     <= '0;
            bal_q     <= '0;
            good_q    <= '0;
            last_up_q <= 1'b0;
            last_dn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            locked_q  <= locked_d;
            flip_q    <= flip_d;
            win_q     <= win_d;
            bal_q     <= bal_d;
            good_q    <= good_d;
            last_up_q <= last_up_d;
            last_dn_q <= last_dn_d;
        end
    end

    always_comb begin
        step = (state_q == S_ACQUIRE) ? CODE_W'(STEP_COARSE) : CODE_W'(STEP_FINE);
        code_step = code_q;
        if (dir_up_q) begin
            code_step = (code_q > CODE_MAX - step) ? CODE_MAX : code_q + step;
        end else if (dir_dn_q) begin
            code_step = (code_q < step) ? '0 : code_q - step;
        end

        dir_val = '0;
        if (dir_up_q) begin
            dir_val = BAL_W'(1);
        end else if (dir_dn_q) begin
            dir_val = '1;
        end
        bal_sum  = bal_q + dir_val;
        bal_mag  = bal_sum[BAL_W-1] ? BAL_W'(-bal_sum) : BAL_W'(bal_sum);
        balanced = (bal_mag <= BAL_W'(LOCK_TOL));
        win_last = (win_q == WIN_W'(WIN_LEN - 1));
        reversal = (dir_up_q & last_dn_q) | (dir_dn_q & last_up_q);
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        locked_d  = locked_q;
        flip_d    = flip_q;
        win_d     = win_q;
        bal_d     = bal_q;
        good_d    = good_q;
        last_up_d = last_up_q;
        last_dn_d = last_dn_q;

        if (!en) begin
            state_d   = S_IDLE;
            code_d    = CODE_RST;
            locked_d  = 1'b0;
            flip_d    = '0;
            win_d     = '0;
            bal_d     = '0;
            good_d    = '0;
            last_up_d = 1'b0;
            last_dn_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ACQUIRE;
                    code_d    = CODE_RST;
                    locked_d  = 1'b0;
                    flip_d    = '0;
                    win_d     = '0;
                    bal_d     = '0;
                    good_d    = '0;
                    last_up_d = 1'b0;
                    last_dn_d = 1'b0;
                end
                S_ACQUIRE: begin
                    code_d = code_step;
                    if (dir_up_q | dir_dn_q) begin
                        last_up_d = dir_up_q;
                        last_dn_d = dir_dn_q;
                    end
                    if (reversal) begin
                        if (flip_q == FLIP_W'(FLIP_CNT - 1)) begin
                            state_d = S_TRACK;
                            flip_d  = '0;
                            win_d   = '0;
                            bal_d   = '0;
                            good_d  = '0;
                        end else begin
                            flip_d = flip_q + 1'b1;
                        end
                    end
                end
                S_TRACK, S_LOCKED: begin
                    code_d = code_step;
                    if (win_last) begin
                        win_d = '0;
                        bal_d = '0;
                        if (balanced) begin
                            // LOCKED parks the good count at its target.
                            if (state_q == S_LOCKED || good_q == GOOD_W'(LOCK_WINS - 1)) begin
                                good_d   = GOOD_W'(LOCK_WINS);
                                state_d  = S_LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end else begin
                            good_d   = '0;
                            state_d  = S_TRACK;
                            locked_d = 1'b0;
                        end
                    end else begin
                        win_d = win_q + 1'b1;
                        bal_d = bal_sum;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign dco_code = code_q;
    assign locked   = locked_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: a behavioural loop model predicts every
// cycle for two instances (default init and init near the top rail).
`timescale 1ns/1ps
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, up, dn;
    logic [7:0] code_a, code_b;
    logic       lk_a, lk_b;
    logic [1:0] st_a, st_b;

    always #5 clk = ~clk;

    pll_lock_ctrl u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
        .dco_code(code_a), .locked(lk_a), .state(st_a)
    );

    pll_lock_ctrl #(.CODE_INIT(250)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
        .dco_code(code_b), .locked(lk_b), .state(st_b)
    );

    typedef struct {
        int st;
        int code;
        int lk;
        int last;
        int flips;
        int inwin;
        int bal;
        int good;
        int pend;
    } model_t;

    typedef struct {
        int st;
        int code;
        int lk;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    model_t m_a, m_b;
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     seen_lock, seen_unlock, seen_top, seen_floor;
    bit     alt_ph;

    function automatic model_t mreset(int init);
        model_t m;
        m = '{st: 0, code: init, lk: 0, last: 0, flips: 0, inwin: 0, bal: 0, good: 0, pend: 0};
        return m;
    endfunction

    function automatic int clamp(int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    // Behaviour from the loop description: direction history, window tallies, lock rules.
    function automatic model_t mstep(model_t m, int init, bit r, bit e, bit u, bit d);
        int dir_now, dir;
        dir_now = (u && !d) ? 1 : (d && !u) ? -1 : 0;
        if (r) return mreset(init);
        dir    = m.pend;
        m.pend = dir_now;
        if (!e) begin
            dir_now = m.pend;
            m = mreset(init);
            m.pend = dir_now;
            return m;
        end
        if (m.st == 0) begin
            m.st = 1;
        end else if (m.st == 1) begin
            m.code = clamp(m.code + 8 * dir);
            if (dir != 0) begin
                if (m.last != 0 && dir != m.last) m.flips++;
                m.last = dir;
            end
            if (m.flips == 4) begin
                m.st = 2; m.flips = 0; m.inwin = 0; m.bal = 0; m.good = 0;
            end
        end else begin
            m.code = clamp(m.code + dir);
            m.bal += dir;
            m.inwin++;
            if (m.inwin == 32) begin
                if (m.bal <= 2 && m.bal >= -2) begin
                    m.good++;
                    if (m.good >= 4) begin
                        m.good = 4; m.st = 3; m.lk = 1;
                    end
                end else begin
                    m.good = 0; m.st = 2; m.lk = 0;
                end
                m.inwin = 0;
                m.bal   = 0;
            end
        end
        return m;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit u, input bit d);
        int prev_st;
        @(negedge clk);
        rst = r; en = e; up = u; dn = d;
        prev_st = m_a.st;
        m_a = mstep(m_a, 128, r, e, u, d);
        m_b = mstep(m_b, 250, r, e, u, d);
        q_a.push_back('{st: m_a.st, code: m_a.code, lk: m_a.lk});
        q_b.push_back('{st: m_b.st, code: m_b.code, lk: m_b.lk});
        if (m_a.lk == 1) seen_lock = 1'b1;
        if (prev_st == 3 && m_a.st == 2) seen_unlock = 1'b1;
        if (m_b.code == 255 && m_b.st == 1) seen_top = 1'b1;
        if (m_a.code == 0 && m_a.st == 1) seen_floor = 1'b1;
    endtask

    task automatic run(input int mode, input int len, input bit randev);
        bit u, d, e, r;
        for (int i = 0; i < len; i++) begin
            e = 1'b1; r = 1'b0;
            case (mode)
                0: begin u = 1'b1; d = 1'b0; end
                1: begin u = 1'b0; d = 1'b1; end
                2: begin
                    if ($urandom_range(9) == 0) begin
                        u = $urandom_range(1); d = u;
                    end else begin
                        u = alt_ph; d = ~alt_ph; alt_ph = ~alt_ph;
                    end
                end
                default: begin u = $urandom_range(1); d = $urandom_range(1); end
            endcase
            if (randev) begin
                if ($urandom_range(399) == 0) e = 1'b0;
                if ($urandom_range(699) == 0) r = 1'b1;
            end
            cyc(r, e, u, d);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                x = q_a.pop_front();
                n_tests++;
                if (st_a !== 2'(x.st) || code_a !== 8'(x.code) || lk_a !== 1'(x.lk)) begin
                    n_fail++;
                    $display("FAIL main t=%0t: got state=%0d code=%0d locked=%0d, expected state=%0d code=%0d locked=%0d",
                             $time, st_a, code_a, lk_a, x.st, x.code, x.lk);
                end
            end
            if (q_b.size() > 0) begin
                x = q_b.pop_front();
                n_tests++;
                if (st_b !== 2'(x.st) || code_b !== 8'(x.code) || lk_b !== 1'(x.lk)) begin
                    n_fail++;
                    $display("FAIL sat t=%0t: got state=%0d code=%0d locked=%0d, expected state=%0d code=%0d locked=%0d",
                             $time, st_b, code_b, lk_b, x.st, x.code, x.lk);
                end
            end
        end
    end

    task automatic cover_chk(input string name, input bit hit);
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL cover_%s: got not reached, expected reached", name);
        end
    endtask

    initial begin : stim
        int mode, len;
        rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0;
        m_a = mreset(128);
        m_b = mreset(250);
        alt_ph = 1'b1;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        run(0, 5, 1'b0);
        run(1, 20, 1'b0);
        run(2, 6, 1'b0);
        run(2, 160, 1'b0);
        run(1, 64, 1'b0);
        run(2, 40, 1'b0);
        cyc(0, 0, 0, 0);
        run(2, 10, 1'b0);
        cyc(1, 1, 1, 0);
        run(0, 8, 1'b0);

        for (int s = 0; s < 150; s++) begin
            mode = $urandom_range(5);
            if (mode >= 3) mode = (mode == 5) ? 3 : 2;
            len = (mode == 2) ? $urandom_range(300, 40) : $urandom_range(80, 8);
            run(mode, len, 1'b1);
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        cover_chk("lock", seen_lock);
        cover_chk("unlock", seen_unlock);
        cover_chk("top_rail", seen_top);
        cover_chk("floor", seen_floor);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
